// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps one instruction-memory request outstanding and squashes stale responses after a redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [6:0]  opcode
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetchPc_q, fetchPc_d;
  logic [31:0] bufInstr_q, bufInstr_d;
  logic [31:0] ifIdPc_q, ifIdPc_d;
  logic [31:0] ifIdInstr_q, ifIdInstr_d;
  logic        ifIdValid_q, ifIdValid_d;
  logic        deliver;
  logic [31:0] deliverInstr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_ISSUE;
      pc_q        <= RESET_PC;
      fetchPc_q   <= RESET_PC;
      bufInstr_q  <= NOP_INSTR;
      ifIdPc_q    <= 32'h0000_0000;
      ifIdInstr_q <= NOP_INSTR;
      ifIdValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetchPc_q   <= fetchPc_d;
      bufInstr_q  <= bufInstr_d;
      ifIdPc_q    <= ifIdPc_d;
      ifIdInstr_q <= ifIdInstr_d;
      ifIdValid_q <= ifIdValid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetchPc_d    = fetchPc_q;
    bufInstr_d   = bufInstr_q;
    ifIdPc_d     = ifIdPc_q;
    ifIdInstr_d  = ifIdInstr_q;
    ifIdValid_d  = ifIdValid_q;
    imem_req     = 1'b0;
    imem_addr    = pc_q;
    deliver      = 1'b0;
    deliverInstr = bufInstr_q;

    case (state_q)
      S_ISSUE: begin
        if (!flush) begin
          imem_req  = 1'b1;
          fetchPc_d = pc_q;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          // A response landing together with the flush is the squashed one.
          state_d = imem_valid ? S_ISSUE : S_DROP;
        end else if (imem_valid) begin
          if (!stall) begin
            deliver      = 1'b1;
            deliverInstr = imem_rdata;
            state_d      = S_ISSUE;
          end else begin
            bufInstr_d = imem_rdata;
            state_d    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_d = S_ISSUE;
        end else if (!stall) begin
          deliver      = 1'b1;
          deliverInstr = bufInstr_q;
          state_d      = S_ISSUE;
        end
      end
      S_DROP: begin
        if (imem_valid) begin
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_ISSUE;
    endcase

    // Flush beats delivery; an idle unstalled cycle inserts a bubble.
    if (flush) begin
      pc_d        = redirect_pc;
      ifIdPc_d    = redirect_pc;
      ifIdInstr_d = NOP_INSTR;
      ifIdValid_d = 1'b0;
    end else if (deliver) begin
      pc_d        = fetchPc_q + 32'd4;
      ifIdPc_d    = fetchPc_q;
      ifIdInstr_d = deliverInstr;
      ifIdValid_d = 1'b1;
    end else if (!stall) begin
      ifIdPc_d    = pc_q;
      ifIdInstr_d = NOP_INSTR;
      ifIdValid_d = 1'b0;
    end

    if (reset) begin
      imem_req = 1'b0;
    end
  end

  assign if_id_pc    = ifIdPc_q;
  assign if_id_instr = ifIdInstr_q;
  assign if_id_valid = ifIdValid_q;
  assign opcode      = ifIdInstr_q[6:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays instruction memory cycle by cycle.
// Inputs change 1ns after each rising edge; outputs are sampled at that point or 1ns later.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [6:0]  opcode;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
    .opcode      (opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_valid = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b0, 32'h0, NOP}) begin
      errors++;
      $display("[TB] FAIL reset_ifid: got v=%b pc=%h instr=%h, want v=0 pc=0 instr=%h", if_id_valid, if_id_pc, if_id_instr, NOP);
    end
    checks++;
    if ({imem_req, opcode} !== {1'b0, 7'h13}) begin
      errors++;
      $display("[TB] FAIL reset_req: got req=%b opcode=%h, want req=0 opcode=13", imem_req, opcode);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("[TB] FAIL first_req: got req=%b addr=%h, want req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  // Memory answers one cycle after each request.
  task automatic test_one_cycle_mem();
    logic [31:0] words [3];
    words = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'(i * 4)}) begin
        errors++;
        $display("[TB] FAIL k1_req%0d: got req=%b addr=%h, want req=1 addr=%h", i, imem_req, imem_addr, i * 4);
      end
      tick();
      checks++;
      if ({imem_req, if_id_valid, if_id_pc} !== {1'b0, 1'b0, 32'(i * 4)}) begin
        errors++;
        $display("[TB] FAIL k1_bubble%0d: got req=%b v=%b pc=%h, want req=0 v=0 pc=%h", i, imem_req, if_id_valid, if_id_pc, i * 4);
      end
      imem_valid = 1'b1; imem_rdata = words[i];
      tick();
      imem_valid = 1'b0;
      checks++;
      if ({if_id_valid, if_id_pc, if_id_instr, opcode} !== {1'b1, 32'(i * 4), words[i], 7'h13}) begin
        errors++;
        $display("[TB] FAIL k1_ifid%0d: got v=%b pc=%h instr=%h op=%h, want v=1 pc=%h instr=%h op=13", i, if_id_valid, if_id_pc, if_id_instr, opcode, i * 4, words[i]);
      end
    end
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0000_000C}) begin
      errors++;
      $display("[TB] FAIL k1_next_req: got req=%b addr=%h, want req=1 addr=0000000c", imem_req, imem_addr);
    end
  endtask

  // Memory answers three cycles after the request at 0xC.
  task automatic test_latency3();
    int reqSeen = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (imem_req) reqSeen++;
      checks++;
      if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b0, 32'h0000_000C, NOP}) begin
        errors++;
        $display("[TB] FAIL k3_bubble%0d: got v=%b pc=%h instr=%h, want v=0 pc=0000000c instr=%h", c, if_id_valid, if_id_pc, if_id_instr, NOP);
      end
    end
    checks++;
    if (reqSeen !== 0) begin
      errors++;
      $display("[TB] FAIL k3_no_req_in_wait: got %0d requests, want 0", reqSeen);
    end
    imem_valid = 1'b1; imem_rdata = 32'h0030_0193;
    tick();
    imem_valid = 1'b0;
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h0000_000C, 32'h0030_0193}) begin
      errors++;
      $display("[TB] FAIL k3_ifid: got v=%b pc=%h instr=%h, want v=1 pc=0000000c instr=00300193", if_id_valid, if_id_pc, if_id_instr);
    end
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0010}) begin
      errors++;
      $display("[TB] FAIL k3_next_req: got req=%b addr=%h, want req=1 addr=00000010", imem_req, imem_addr);
    end
  endtask

  // Reset while waiting; the late response shows up in ISSUE and must be ignored.
  task automatic test_reset_midop();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("[TB] FAIL midrst_req: got req=%b addr=%h, want req=1 addr=0", imem_req, imem_addr);
    end
    tick();
    imem_valid = 1'b0;
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b0, 32'h0, NOP}) begin
      errors++;
      $display("[TB] FAIL midrst_ignored: got v=%b pc=%h instr=%h, want v=0 pc=0 instr=%h", if_id_valid, if_id_pc, if_id_instr, NOP);
    end
    imem_valid = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_valid = 1'b0;
    checks++;
    if ({if_id_valid, if_id_pc} !== {1'b1, 32'h0}) begin
      errors++;
      $display("[TB] FAIL midrst_fetch0: got v=%b pc=%h, want v=1 pc=0", if_id_valid, if_id_pc);
    end
  endtask

  // Stall held for four cycles across the response of 0x8.
  task automatic test_stall();
    tick();
    imem_valid = 1'b1; imem_rdata = 32'h0010_0093;
    tick();
    imem_valid = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0008}) begin
      errors++;
      $display("[TB] FAIL stall_req8: got req=%b addr=%h, want req=1 addr=00000008", imem_req, imem_addr);
    end
    tick();
    stall = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h00A0_0093;
    for (int c = 0; c < 4; c++) begin
      tick();
      imem_valid = 1'b0;
      if (c == 3) stall = 1'b0;
      #1;
      checks++;
      if ({imem_req, if_id_valid, if_id_pc, if_id_instr} !== {1'b0, 1'b0, 32'h0000_0008, NOP}) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got req=%b v=%b pc=%h instr=%h, want req=0 v=0 pc=00000008 instr=%h", c, imem_req, if_id_valid, if_id_pc, if_id_instr, NOP);
      end
    end
    tick();
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h0000_0008, 32'h00A0_0093}) begin
      errors++;
      $display("[TB] FAIL stall_release: got v=%b pc=%h instr=%h, want v=1 pc=00000008 instr=00a00093", if_id_valid, if_id_pc, if_id_instr);
    end
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0000_000C}) begin
      errors++;
      $display("[TB] FAIL stall_next_req: got req=%b addr=%h, want req=1 addr=0000000c", imem_req, imem_addr);
    end
  endtask

  // Flush while waiting: bubble, stale response dropped, refetch at 0x100.
  task automatic test_flush_wait();
    tick();
    flush = 1'b1; redirect_pc = 32'h0000_0100;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flushw_req: got req=%b, want 0", imem_req);
    end
    tick();
    flush = 1'b0;
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b0, 32'h0000_0100, NOP}) begin
      errors++;
      $display("[TB] FAIL flushw_bubble: got v=%b pc=%h instr=%h, want v=0 pc=00000100 instr=%h", if_id_valid, if_id_pc, if_id_instr, NOP);
    end
    tick();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flushw_drop_noreq: got req=%b, want 0", imem_req);
    end
    imem_valid = 1'b1; imem_rdata = 32'hBADB_AD13;
    tick();
    imem_valid = 1'b0;
    checks++;
    if ({if_id_valid, if_id_instr} !== {1'b0, NOP}) begin
      errors++;
      $display("[TB] FAIL flushw_stale: got v=%b instr=%h, want v=0 instr=%h", if_id_valid, if_id_instr, NOP);
    end
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0100}) begin
      errors++;
      $display("[TB] FAIL flushw_next_req: got req=%b addr=%h, want req=1 addr=00000100", imem_req, imem_addr);
    end
  endtask

  // Flush and stall together while holding a buffered word: flush wins.
  task automatic test_flush_hold();
    tick();
    stall = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h1234_5013;
    tick();
    imem_valid = 1'b0; flush = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    flush = 1'b0; stall = 1'b0;
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b0, 32'h0000_0100, NOP}) begin
      errors++;
      $display("[TB] FAIL flushh_bubble: got v=%b pc=%h instr=%h, want v=0 pc=00000100 instr=%h", if_id_valid, if_id_pc, if_id_instr, NOP);
    end
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0100}) begin
      errors++;
      $display("[TB] FAIL flushh_next_req: got req=%b addr=%h, want req=1 addr=00000100", imem_req, imem_addr);
    end
    tick();
    imem_valid = 1'b1; imem_rdata = 32'h0050_0293;
    tick();
    imem_valid = 1'b0;
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h0000_0100, 32'h0050_0293}) begin
      errors++;
      $display("[TB] FAIL flushh_refetch: got v=%b pc=%h instr=%h, want v=1 pc=00000100 instr=00500293", if_id_valid, if_id_pc, if_id_instr);
    end
  endtask

  // Redirect from ISSUE to the top word, then wrap to 0.
  task automatic test_wrap();
    flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_flush_noreq: got req=%b, want 0", imem_req);
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr, if_id_pc} !== {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC}) begin
      errors++;
      $display("[TB] FAIL wrap_req: got req=%b addr=%h ifpc=%h, want req=1 addr=fffffffc ifpc=fffffffc", imem_req, imem_addr, if_id_pc);
    end
    tick();
    imem_valid = 1'b1; imem_rdata = 32'hFFC0_0013;
    tick();
    imem_valid = 1'b0;
    checks++;
    if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'hFFFF_FFFC, 32'hFFC0_0013}) begin
      errors++;
      $display("[TB] FAIL wrap_ifid: got v=%b pc=%h instr=%h, want v=1 pc=fffffffc instr=ffc00013", if_id_valid, if_id_pc, if_id_instr);
    end
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("[TB] FAIL wrap_next_req: got req=%b addr=%h, want req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  // Flush in WAIT with the response in the same cycle goes straight back to ISSUE.
  task automatic test_back_to_back();
    tick();
    flush = 1'b1; redirect_pc = 32'h0000_0040;
    imem_valid = 1'b1; imem_rdata = 32'hBAD0_0013;
    tick();
    flush = 1'b0; imem_valid = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr, if_id_valid, if_id_instr} !== {1'b1, 32'h0000_0040, 1'b0, NOP}) begin
      errors++;
      $display("[TB] FAIL flushv_req: got req=%b addr=%h v=%b instr=%h, want req=1 addr=00000040 v=0 instr=%h", imem_req, imem_addr, if_id_valid, if_id_instr, NOP);
    end
  endtask

  initial begin
    test_reset();
    test_one_cycle_mem();
    test_latency3();
    test_reset_midop();
    test_stall();
    test_flush_wait();
    test_flush_hold();
    test_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
